// File: rtl/ahb_sram_master.sv
// AHB-Lite master that turns SINGLE/INCR4 commands into bus transfers.
// It rejects illegal commands without touching the bus and reports errors through done/rsp_err.
module ahb_sram_master (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_incr4,
    input  logic [31:0] wdata,
    output logic        wdata_pop,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        rsp_err,
    output logic        hsel,
    output logic [1:0]  htrans,
    output logic [1:0]  hsize,
    output logic [3:0]  hburst,
    output logic        hwrite,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic [2:0]  hresp
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [3:0] BURST_SINGLE = 4'd0;
    localparam logic [3:0] BURST_INCR4  = 4'd3;
    localparam logic [2:0] RESP_OKAY    = 3'b000;
    localparam logic [2:0] RESP_ERROR   = 3'b001;

    typedef enum logic [2:0] {IDLE, ADDR, BURST, DRAIN, ERR} state_e;

    state_e      state_q, state_d;
    logic        hsel_q, hsel_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [1:0]  hsize_q, hsize_d;
    logic [3:0]  hburst_q, hburst_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        done_q, done_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  beat_q, beat_d;
    logic        dphase_q, dphase_d;

    logic        addr_phase;
    logic        last_beat;
    logic        misaligned;
    logic        crosses_1k;
    logic        cmd_illegal;
    logic [5:0]  burst_bytes;
    logic [10:0] end_offset;
    logic [2:0]  beat_bytes;

    // An INCR4 burst is illegal if its last byte lands in the next 1 KB page.
    always_comb begin
        misaligned  = ((cmd_size == 2'd1) && cmd_addr[0]) ||
                      ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));
        burst_bytes = 6'd4 << cmd_size;
        end_offset  = {1'b0, cmd_addr[9:0]} + {5'd0, burst_bytes} - 11'd1;
        crosses_1k  = cmd_incr4 && end_offset[10];
        cmd_illegal = (cmd_size == 2'd3) || misaligned || crosses_1k;
    end

    assign addr_phase = (state_q == ADDR) || (state_q == BURST);
    assign last_beat  = (hburst_q != BURST_INCR4) || (beat_q == 2'd3);
    assign beat_bytes = 3'd1 << hsize_q;
    assign cmd_ready  = (state_q == IDLE);
    assign wdata_pop  = addr_phase && hready && hwrite_q;

    // NOTE: every signal gets its hold/default value before the case so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        hsel_d        = hsel_q;
        htrans_d      = htrans_q;
        hsize_d       = hsize_q;
        hburst_d      = hburst_q;
        hwrite_d      = hwrite_q;
        haddr_d       = haddr_q;
        hwdata_d      = hwdata_q;
        rdata_d       = rdata_q;
        beat_d        = beat_q;
        dphase_d      = dphase_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        rsp_err_d     = 1'b0;

        if (hready) dphase_d = addr_phase;
        if (dphase_q && hready && (hresp == RESP_OKAY) && !hwrite_q) begin
            rdata_d       = hrdata;
            rdata_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal) begin
                        done_d    = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d  = ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = TRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hsize_d  = cmd_size;
                        hwrite_d = cmd_write;
                        hburst_d = cmd_incr4 ? BURST_INCR4 : BURST_SINGLE;
                        beat_d   = 2'd0;
                    end
                end
            end
            ADDR, BURST: begin
                if (dphase_q && !hready && (hresp == RESP_ERROR)) begin
                    // Cancel the pending address phase on the first error cycle.
                    state_d  = ERR;
                    hsel_d   = 1'b0;
                    htrans_d = TRANS_IDLE;
                end else if (hready) begin
                    if (hwrite_q) hwdata_d = wdata;
                    if (last_beat) begin
                        state_d  = DRAIN;
                        hsel_d   = 1'b0;
                        htrans_d = TRANS_IDLE;
                    end else begin
                        state_d  = BURST;
                        htrans_d = TRANS_SEQ;
                        haddr_d  = haddr_q + {29'd0, beat_bytes};
                        beat_d   = beat_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (!hready && (hresp == RESP_ERROR)) begin
                    state_d = ERR;
                end else if (hready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                if (hready) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q       <= IDLE;
            hsel_q        <= 1'b0;
            htrans_q      <= TRANS_IDLE;
            hsize_q       <= 2'd0;
            hburst_q      <= BURST_SINGLE;
            hwrite_q      <= 1'b0;
            haddr_q       <= 32'd0;
            hwdata_q      <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            rsp_err_q     <= 1'b0;
            beat_q        <= 2'd0;
            dphase_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hsel_q        <= hsel_d;
            htrans_q      <= htrans_d;
            hsize_q       <= hsize_d;
            hburst_q      <= hburst_d;
            hwrite_q      <= hwrite_d;
            haddr_q       <= haddr_d;
            hwdata_q      <= hwdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            rsp_err_q     <= rsp_err_d;
            beat_q        <= beat_d;
            dphase_q      <= dphase_d;
        end
    end

    assign hsel        = hsel_q;
    assign htrans      = htrans_q;
    assign hsize       = hsize_q;
    assign hburst      = hburst_q;
    assign hwrite      = hwrite_q;
    assign haddr       = haddr_q;
    assign hwdata      = hwdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_ahb_sram_master.sv
// Directed bench for ahb_sram_master: single/burst reads and writes, stalls, errors, illegal commands, reset.
module tb_ahb_sram_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_incr4;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] wdata, rdata, hwdata, haddr, hrdata;
    logic        wdata_pop, rdata_valid, done, rsp_err;
    logic        hsel, hwrite, hready;
    logic [1:0]  htrans, hsize;
    logic [3:0]  hburst;
    logic [2:0]  hresp;

    int checks  = 0;
    int errors  = 0;
    int pop_cnt = 0;

    logic [31:0] ill_addr [3] = '{32'h3, 32'h0, 32'h3F8};
    logic [1:0]  ill_size [3] = '{2'd1, 2'd3, 2'd2};
    logic        ill_inc  [3] = '{1'b0, 1'b0, 1'b1};

    ahb_sram_master dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4),
        .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
        .done(done), .rsp_err(rsp_err),
        .hsel(hsel), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already set; count a pop for this cycle, then step past the next rising edge.
    task automatic cycle();
        #1;
        if (wdata_pop) pop_cnt++;
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic inc);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_incr4 = inc;
        cycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_incr4 = 1'b0;
        wdata = '0; hready = 1'b1; hrdata = '0; hresp = 3'b000;

        repeat (2) @(posedge hclk);
        #1;
        check("rst_htrans", htrans, 0);
        check("rst_hsel", hsel, 0);
        check("rst_haddr", haddr, 0);
        check("rst_done", done, 0);
        check("rst_rvalid", rdata_valid, 0);
        hreset = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pop", wdata_pop, 0);

        // Single word write
        pop_cnt = 0;
        wdata   = 32'hA5A5_5A5A;
        issue(1'b1, 32'h10, 2'd2, 1'b0);
        check("a_htrans", htrans, 32'h2);
        check("a_hsel", hsel, 1);
        check("a_haddr", haddr, 32'h10);
        check("a_hburst", hburst, 0);
        check("a_hwrite", hwrite, 1);
        check("a_cmd_ready", cmd_ready, 0);
        cycle();
        check("a_pop", pop_cnt, 1);
        check("a_hwdata", hwdata, 32'hA5A5_5A5A);
        check("a_htrans_idle", htrans, 0);
        check("a_done_early", done, 0);
        cycle();
        check("a_done", done, 1);
        check("a_err", rsp_err, 0);
        check("a_cmd_ready2", cmd_ready, 1);

        // INCR4 word read
        issue(1'b0, 32'h100, 2'd2, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                check("b_htrans", htrans, (k == 1) ? 32'd2 : 32'd3);
                check("b_haddr", haddr, 32'h100 + 32'(4 * (k - 1)));
                check("b_hburst", hburst, 3);
            end else begin
                check("b_htrans_idle", htrans, 0);
            end
            if (k >= 3) begin
                check("b_rvalid", rdata_valid, 1);
                check("b_rdata", rdata, 32'(k - 2));
            end else begin
                check("b_rvalid0", rdata_valid, 0);
            end
            check("b_done", done, 32'(k == 6));
            hrdata = 32'(k - 1);
            if (k < 6) cycle();
        end

        // INCR4 write, two wait states on the third address phase
        pop_cnt = 0;
        wdata   = 32'hC0DE_0000;
        issue(1'b1, 32'h200, 2'd2, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            hready = !(k == 3 || k == 4);
            wdata  = 32'hC0DE_0000 + 32'(pop_cnt);
            if (k >= 3 && k <= 5) begin
                check("c_haddr", haddr, 32'h208);
                check("c_htrans", htrans, 3);
                check("c_hwdata", hwdata, 32'hC0DE_0001);
            end
            cycle();
        end
        hready = 1'b1;
        check("c_pops", pop_cnt, 4);
        check("c_done", done, 1);
        check("c_err", rsp_err, 0);
        check("c_hwdata_last", hwdata, 32'hC0DE_0003);

        // INCR4 read, ERROR response on the second beat's data phase
        issue(1'b0, 32'h300, 2'd2, 1'b1);
        cycle();
        hrdata = 32'h11;
        cycle();
        check("d_rvalid_b0", rdata_valid, 1);
        check("d_rdata_b0", rdata, 32'h11);
        check("d_haddr", haddr, 32'h308);
        hready = 1'b0; hresp = 3'b001; hrdata = 32'h22;
        cycle();
        check("d_htrans_idle", htrans, 0);
        check("d_hsel", hsel, 0);
        check("d_rvalid_err", rdata_valid, 0);
        check("d_done_early", done, 0);
        hready = 1'b1;
        cycle();
        check("d_done", done, 1);
        check("d_err", rsp_err, 1);
        check("d_rvalid_none", rdata_valid, 0);
        check("d_htrans_after", htrans, 0);
        hresp = 3'b000;
        cycle();
        check("d_done_clr", done, 0);

        // Illegal commands, accepted back to back
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, ill_addr[i], ill_size[i], ill_inc[i]);
            check("e_hsel", hsel, 0);
            check("e_htrans", htrans, 0);
            check("e_done", done, 1);
            check("e_err", rsp_err, 1);
        end
        cycle();
        check("e_done_clr", done, 0);

        // INCR4 ending exactly at a 1 KB boundary is legal; next command back to back
        issue(1'b0, 32'h3F0, 2'd2, 1'b1);
        check("f_hsel", hsel, 1);
        check("f_haddr", haddr, 32'h3F0);
        repeat (5) cycle();
        check("f_done", done, 1);
        check("f_err", rsp_err, 0);
        issue(1'b0, 32'h21, 2'd0, 1'b0);
        check("g_htrans", htrans, 2);
        check("g_haddr", haddr, 32'h21);
        check("g_hsize", hsize, 0);
        cycle();
        hrdata = 32'hBEEF;
        cycle();
        check("g_done", done, 1);
        check("g_rdata", rdata, 32'hBEEF);
        check("g_rvalid", rdata_valid, 1);

        // Asynchronous reset in the middle of an INCR4 read
        issue(1'b0, 32'h100, 2'd2, 1'b1);
        hrdata = 32'h1;
        cycle();
        hrdata = 32'h2;
        cycle();
        check("h_pre_htrans", htrans, 3);
        check("h_pre_haddr", haddr, 32'h108);
        #1 hreset = 1'b1;
        #1;
        check("h_htrans", htrans, 0);
        check("h_hsel", hsel, 0);
        check("h_haddr", haddr, 0);
        check("h_hburst", hburst, 0);
        check("h_rvalid", rdata_valid, 0);
        check("h_rdata", rdata, 0);
        check("h_cmd_ready", cmd_ready, 1);
        @(posedge hclk);
        #1 hreset = 1'b0;
        check("h_no_done", done, 0);
        cycle();
        check("h_no_done2", done, 0);
        issue(1'b0, 32'h40, 2'd2, 1'b0);
        check("h_htrans_new", htrans, 2);
        check("h_haddr_new", haddr, 32'h40);
        cycle();
        hrdata = 32'h5555_AAAA;
        cycle();
        check("h_done", done, 1);
        check("h_err", rsp_err, 0);
        check("h_rdata", rdata, 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
